// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - decode-stage branch prediction resolver with fetch redirect and statistics
module branch_resolver (
   input  logic        clk,
   input  logic        reset,
   input  logic        predictionF,
   input  logic [31:0] predictedPCF,
   input  logic        stallD,
   input  logic [31:0] PCD,
   input  logic        isBranchD,
   input  logic        branchTakenD,
   input  logic [31:0] branchTargetD,
   output logic        redirectF,
   output logic [31:0] redirectPC,
   output logic        flushD,
   output logic        updateBTB,
   output logic [31:0] branchCount,
   output logic [31:0] mispredictCount
);

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        valid_q, valid_d;
   logic        prediction_q, prediction_d;
   logic [31:0] predicted_pc_q, predicted_pc_d;
   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

   logic        resolve;
   logic        taken_actual;
   logic        mispredict;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;

   // Compare the carried prediction against the decode outcome and pick the corrected PC.
   // The SQUASH term is redundant with valid_q=0 but keeps the one-redirect-per-two-cycles
   // guarantee independent of the D-register update path.
   always_comb begin
      resolve      = valid_q & ~stallD & (state_q == RUN);
      taken_actual = isBranchD & branchTakenD;
      pc_plus4     = PCD + 32'd4;
      mispredict   = 1'b0;
      redirect_pc  = 32'd0;
      if (resolve) begin
         if (prediction_q && !taken_actual) begin
            mispredict  = 1'b1;
            redirect_pc = pc_plus4;
         end else if (!prediction_q && taken_actual) begin
            mispredict  = 1'b1;
            redirect_pc = branchTargetD;
         end else if (prediction_q && taken_actual && (predicted_pc_q != branchTargetD)) begin
            mispredict  = 1'b1;
            redirect_pc = branchTargetD;
         end
      end
   end

   assign redirectF       = mispredict;
   assign flushD          = mispredict;
   assign redirectPC      = redirect_pc;
   assign updateBTB       = resolve & isBranchD;
   assign branchCount     = branch_cnt_q;
   assign mispredictCount = mispredict_cnt_q;

   // Next-state for the squash FSM, D-stage prediction registers and statistics counters.
   always_comb begin
      state_d          = state_q;
      valid_d          = valid_q;
      prediction_d     = prediction_q;
      predicted_pc_d   = predicted_pc_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;

      case (state_q)
         RUN:     if (mispredict) state_d = SQUASH;
         SQUASH:  state_d = RUN;
         default: state_d = RUN;
      endcase

      if (flushD) begin
         valid_d        = 1'b0;
         prediction_d   = 1'b0;
         predicted_pc_d = 32'd0;
      end else if (!stallD) begin
         valid_d        = 1'b1;
         prediction_d   = predictionF;
         predicted_pc_d = predictedPCF;
      end

      if (updateBTB) branch_cnt_d     = branch_cnt_q + 32'd1;
      if (redirectF) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
   end

   // State register: synchronous reset clears everything and returns the FSM to RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= RUN;
         valid_q          <= 1'b0;
         prediction_q     <= 1'b0;
         predicted_pc_q   <= 32'd0;
         branch_cnt_q     <= 32'd0;
         mispredict_cnt_q <= 32'd0;
      end else begin
         state_q          <= state_d;
         valid_q          <= valid_d;
         prediction_q     <= prediction_d;
         predicted_pc_q   <= predicted_pc_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

   logic        clk;
   logic        reset;
   logic        predictionF;
   logic [31:0] predictedPCF;
   logic        stallD;
   logic [31:0] PCD;
   logic        isBranchD;
   logic        branchTakenD;
   logic [31:0] branchTargetD;
   logic        redirectF;
   logic [31:0] redirectPC;
   logic        flushD;
   logic        updateBTB;
   logic [31:0] branchCount;
   logic [31:0] mispredictCount;

   int vectors;
   int miscompares;

   branch_resolver dut (
      .clk             (clk),
      .reset           (reset),
      .predictionF     (predictionF),
      .predictedPCF    (predictedPCF),
      .stallD          (stallD),
      .PCD             (PCD),
      .isBranchD       (isBranchD),
      .branchTakenD    (branchTakenD),
      .branchTargetD   (branchTargetD),
      .redirectF       (redirectF),
      .redirectPC      (redirectPC),
      .flushD          (flushD),
      .updateBTB       (updateBTB),
      .branchCount     (branchCount),
      .mispredictCount (mispredictCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks the four per-cycle resolution outputs at once.
   task automatic chk_out(input string tag, input logic rf, input logic [31:0] rpc, input logic upd);
      chk({tag, ".redirectF"}, {31'd0, redirectF}, {31'd0, rf});
      chk({tag, ".flushD"},    {31'd0, flushD},    {31'd0, rf});
      chk({tag, ".redirectPC"}, redirectPC, rpc);
      chk({tag, ".updateBTB"}, {31'd0, updateBTB}, {31'd0, upd});
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] bc, input logic [31:0] mc);
      chk({tag, ".branchCount"},     branchCount,     bc);
      chk({tag, ".mispredictCount"}, mispredictCount, mc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
      PCD           = pc;
      isBranchD     = br;
      branchTakenD  = tk;
      branchTargetD = tgt;
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      predictionF  = 1'b0;
      predictedPCF = 32'd0;
      stallD       = 1'b0;
      set_d(32'd0, 1'b0, 1'b0, 32'd0);

      // reset held two cycles
      tick();
      tick();
      chk_out("reset", 1'b0, 32'd0, 1'b0);
      chk_cnt("reset", 32'd0, 32'd0);

      // first instruction: not predicted, non-branch
      reset = 1'b0;
      tick();
      set_d(32'h100, 1'b0, 1'b0, 32'd0);
      predictionF  = 1'b1;
      predictedPCF = 32'h200;
      #1;
      chk_out("nonbranch", 1'b0, 32'd0, 1'b0);

      // correctly predicted taken
      tick();
      set_d(32'h140, 1'b1, 1'b1, 32'h200);
      predictionF  = 1'b0;
      predictedPCF = 32'd0;
      #1;
      chk_out("correct_taken", 1'b0, 32'd0, 1'b1);

      // missed taken
      tick();
      chk_cnt("after_correct", 32'd1, 32'd0);
      set_d(32'h180, 1'b1, 1'b1, 32'h80);
      predictionF  = 1'b1;
      predictedPCF = 32'h300;
      #1;
      chk_out("missed_taken", 1'b1, 32'h80, 1'b1);

      // squash cycle: D invalid, nothing resolves
      tick();
      chk_cnt("after_missed", 32'd2, 32'd1);
      set_d(32'h184, 1'b1, 1'b1, 32'h999);
      #1;
      chk_out("squash1", 1'b0, 32'd0, 1'b0);

      // wrong target
      tick();
      set_d(32'h2F0, 1'b1, 1'b1, 32'h340);
      predictionF  = 1'b1;
      predictedPCF = 32'h1234;
      #1;
      chk_out("wrong_target", 1'b1, 32'h340, 1'b1);

      tick();
      chk_cnt("after_wrong_tgt", 32'd3, 32'd2);
      #1;
      chk_out("squash2", 1'b0, 32'd0, 1'b0);

      // false taken at top of address space: PC+4 wraps to 0
      tick();
      set_d(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h40);
      predictionF  = 1'b0;
      predictedPCF = 32'd0;
      #1;
      chk_out("false_taken_wrap", 1'b1, 32'h0, 1'b1);

      tick();
      chk_cnt("after_wrap", 32'd4, 32'd3);
      #1;
      chk_out("squash3", 1'b0, 32'd0, 1'b0);

      // mispredict held under stall for three cycles
      tick();
      stallD = 1'b1;
      set_d(32'h400, 1'b1, 1'b1, 32'h500);
      predictionF = 1'b1;
      #1;
      chk_out("stall1", 1'b0, 32'd0, 1'b0);
      tick();
      chk_out("stall2", 1'b0, 32'd0, 1'b0);
      tick();
      chk_out("stall3", 1'b0, 32'd0, 1'b0);
      chk_cnt("during_stall", 32'd4, 32'd3);
      stallD = 1'b0;
      #1;
      chk_out("stall_release", 1'b1, 32'h500, 1'b1);

      // reset during the squash cycle
      tick();
      chk_cnt("after_stall", 32'd5, 32'd4);
      reset = 1'b1;
      tick();
      chk_cnt("reset_in_squash", 32'd0, 32'd0);
      chk_out("reset_in_squash", 1'b0, 32'd0, 1'b0);
      reset       = 1'b0;
      predictionF = 1'b0;
      set_d(32'h600, 1'b1, 1'b1, 32'h700);
      #1;
      chk_out("post_reset_invalid", 1'b0, 32'd0, 1'b0);

      // one edge later the FSM is in RUN and D is valid again
      tick();
      chk_out("post_reset_resolve", 1'b1, 32'h700, 1'b1);
      tick();
      chk_cnt("post_reset_counts", 32'd1, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Decode-stage companion to the fetch-stage branch target buffer: carries each fetch-time prediction (taken bit, predicted target) alongside its instruction into decode, compares it with the branch outcome computed there, and on a mismatch redirects fetch and squashes the wrong-path instruction. It also drives the buffer's training strobe and keeps branch and mispredict statistics. It sits between the fetch PC mux, the F/D pipeline register and the hazard unit.

## Interface
- No parameters; PC width fixed at 32, counters fixed at 32.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- predictionF  in  1  fetch-time taken prediction from the target buffer.
- predictedPCF  in  32  fetch-time predicted target from the target buffer.
- stallD  in  1  hazard unit holds F/D; decode cannot resolve this cycle (includes branch stall).
- PCD  in  32  PC of the instruction in decode.
- isBranchD  in  1  decode instruction is a conditional branch.
- branchTakenD  in  1  resolved branch outcome (meaningful only with isBranchD).
- branchTargetD  in  32  resolved taken target.
- redirectF  out  1  fetch must load redirectPC at the next edge.
- redirectPC  out  32  corrected fetch PC.
- flushD  out  1  squash the F/D register (wrong-path instruction) at the next edge.
- updateBTB  out  1  training strobe to the target buffer (resolved branch this cycle).
- branchCount  out  32  resolved branches since reset.
- mispredictCount  out  32  redirects since reset.

## Operation
- Internal D-stage registers: validD, predictionD, predictedPCD.
- Register update priority per edge: reset -> all 0; else flushD -> validD=0, predictionD=0, predictedPCD=0; else !stallD -> validD=1, predictionD=predictionF, predictedPCD=predictedPCF; else hold.
- resolve = validD & !stallD. No output other than counters/registers reflects D when resolve=0.
- Expected next PC when resolve: isBranchD & branchTakenD -> branchTargetD; otherwise PCD+4 (32-bit wrap).
- Mispredict (resolve required), any of:
  - predictionD=1 and (not branch or branch not taken) -> redirectPC=PCD+4.
  - predictionD=0 and branch taken -> redirectPC=branchTargetD.
  - predictionD=1, branch taken, predictedPCD != branchTargetD -> redirectPC=branchTargetD.
- Correct prediction (taken with matching target, or not-taken with not-taken/non-branch) -> no redirect.
- redirectF = flushD = mispredict. redirectPC = 0 when redirectF=0.
- updateBTB = resolve & isBranchD.
- branchCount += 1 on updateBTB; mispredictCount += 1 on redirectF; both wrap at 2^32.
- Squash FSM (two states): RUN, SQUASH. RUN -> SQUASH on redirectF; SQUASH -> RUN unconditionally next edge. In SQUASH validD is already 0, so no resolution, redirect or count occurs; guarantees at most one redirect per two cycles. reset forces RUN.

## Timing
- Reset values: all outputs 0, validD=0, state RUN; first instruction after reset is resolvable one edge after reset deasserts with stallD=0.
- Resolution latency: prediction captured at edge N (F->D), compared combinationally in cycle N, redirectF/flushD/updateBTB valid same cycle, acted on at edge N+1.
- stallD high: outputs redirectF/flushD/updateBTB held 0 for every stalled cycle; D registers hold; resolution occurs once, in the first cycle with stallD=0.
- Redirect and stall never coincide (resolve requires !stallD).
- reset asserted mid-SQUASH or mid-stall: next edge returns to reset state; counters cleared.
- Counters sample updateBTB/redirectF at the edge ending the resolving cycle.

## Test plan
- Reset: hold reset 2 cycles -> all outputs 0, counters 0; release, predictionF=0, PCD=0x100 non-branch -> no redirect, updateBTB=0.
- Correct taken: predictionF=1, predictedPCF=0x200; next cycle PCD=0x140, isBranchD=1, taken, target 0x200 -> redirectF=0, updateBTB=1, branchCount=1.
- Missed taken: predictionF=0; PCD=0x180, taken, target 0x80 -> redirectF=flushD=1, redirectPC=0x80, mispredictCount=1; following cycle validD=0, no outputs.
- Wrong target / false taken: prediction 1 to 0x300 vs target 0x340 -> redirectPC=0x340; prediction 1 on not-taken at PCD=0xFFFFFFFC -> redirectPC=0x00000000 (wrap).
- Stall: branch mispredict held in D with stallD=1 for 3 cycles -> no redirect/update; stallD drops -> single redirect, counts increment by exactly 1.
- Reset during SQUASH: mispredict, then reset next cycle -> counters 0, state RUN, validD=0.
